// File: rtl/usbh_reg_mux.sv
// ============================================================================
//  Module   : usbh_reg_mux
//  Brief    : Register-bus fan-out to NCH USB1.1 host cores with a global
//             interrupt block; optional access timeout via USBH_REG_MUX_TMO_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usbh_reg_mux #(
    parameter int NCH   = 2,
    parameter int AW    = 9,
    parameter int TMO_W = 8
) (
    input  logic              usb_clk_i,
    input  logic              usb_rstn_i,
    input  logic              reg_cs,
    input  logic              reg_wr,
    input  logic [AW-1:0]     reg_addr,
    input  logic [31:0]       reg_wdata,
    input  logic [3:0]        reg_be,
    output logic [31:0]       reg_rdata,
    output logic              reg_ack,
    output logic              reg_err,
    output logic [NCH-1:0]    ch_cs_o,
    output logic              ch_wr_o,
    output logic [5:0]        ch_addr_o,
    output logic [31:0]       ch_wdata_o,
    output logic [3:0]        ch_be_o,
    input  logic [NCH*32-1:0] ch_rdata_i,
    input  logic [NCH-1:0]    ch_ack_i,
    input  logic [NCH-1:0]    ch_intr_i,
    output logic              usb_intr_o
);

    localparam int            IW   = AW - 6;
    localparam int            CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] GIDX = IW'(NCH);

    if ((NCH < 1) || (NCH > 8) || (AW < 6 + $clog2(NCH + 1)) || (TMO_W < 1)) begin : g_param_err
        $error("usbh_reg_mux: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CH_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  idx;
    logic [5:0]     ofs;
    logic [CW-1:0]  sel;
    logic           ack_sel;
    logic [31:0]    rdata_sel;
    logic           start_ch, glb_acc, bad_acc, ch_done, tmo_hit;
    logic [NCH-1:0] intr_q, intr_sts, intr_mask, sts_clr;
    logic [31:0]    glb_rdata;

    assign idx       = reg_addr[AW-1:6];
    assign ofs       = reg_addr[5:0];
    assign ack_sel   = ch_ack_i[sel];
    assign rdata_sel = ch_rdata_i[{sel, 5'd0} +: 32];
    assign reg_ack   = (state == RESP);

`ifdef USBH_REG_MUX_TMO_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);
    logic [TMO_W-1:0] tmo_cnt;

    // The cycle in which the counter would reach its limit is the last one
    // a channel ack is still accepted.
    always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
        if (!usb_rstn_i)              tmo_cnt <= '0;
        else if (start_ch)            tmo_cnt <= '0;
        else if (state == CH_WAIT)    tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
        if (!usb_rstn_i) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ch  = 1'b0;
        glb_acc   = 1'b0;
        bad_acc   = 1'b0;
        ch_done   = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (reg_cs) begin
                    start_ch  = (idx < GIDX);
                    glb_acc   = (idx == GIDX);
                    bad_acc   = (idx > GIDX);
                    state_nxt = (idx < GIDX) ? CH_WAIT : RESP;
                end
            end
            CH_WAIT: begin
                if (ack_sel) begin
                    ch_done   = 1'b1;
                    state_nxt = RESP;
                end
`ifdef USBH_REG_MUX_TMO_EN
                else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = RESP;
                end
`endif
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        glb_rdata = 32'h0;
        case (ofs)
            6'h00:   glb_rdata = {{(32-NCH){1'b0}}, intr_sts};
            6'h04:   glb_rdata = {{(32-NCH){1'b0}}, intr_mask};
            6'h08:   glb_rdata = {16'h0001, 8'h00, 8'(NCH)};
            default: glb_rdata = 32'h0;
        endcase
    end

    assign sts_clr = (glb_acc && reg_wr && (ofs == 6'h00) && reg_be[0]) ?
                     reg_wdata[NCH-1:0] : '0;

    always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
        if (!usb_rstn_i) begin
            intr_q     <= '0;
            intr_sts   <= '0;
            intr_mask  <= '0;
            usb_intr_o <= 1'b0;
        end else begin
            intr_q     <= ch_intr_i;
            // New edges are OR-ed in after the clear so a coincident set wins.
            intr_sts   <= (intr_sts & ~sts_clr) | (ch_intr_i & ~intr_q);
            if (glb_acc && reg_wr && (ofs == 6'h04) && reg_be[0])
                intr_mask <= reg_wdata[NCH-1:0];
            usb_intr_o <= |(intr_sts & intr_mask);
        end
    end

    always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
        if (!usb_rstn_i) begin
            ch_cs_o    <= '0;
            ch_wr_o    <= 1'b0;
            ch_addr_o  <= '0;
            ch_wdata_o <= '0;
            ch_be_o    <= '0;
            sel        <= '0;
            reg_rdata  <= '0;
            reg_err    <= 1'b0;
        end else begin
            if (start_ch) begin
                ch_cs_o    <= NCH'(1) << idx;
                ch_wr_o    <= reg_wr;
                ch_addr_o  <= ofs;
                ch_wdata_o <= reg_wdata;
                ch_be_o    <= reg_be;
                sel        <= idx[CW-1:0];
            end
            if (ch_done) begin
                ch_cs_o   <= '0;
                reg_rdata <= rdata_sel;
                reg_err   <= 1'b0;
            end
            if (tmo_hit) begin
                ch_cs_o   <= '0;
                reg_rdata <= 32'hFFFF_FFFF;
                reg_err   <= 1'b1;
            end
            if (glb_acc) begin
                reg_rdata <= glb_rdata;
                reg_err   <= 1'b0;
            end
            if (bad_acc) begin
                reg_rdata <= 32'hFFFF_FFFF;
                reg_err   <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usbh_reg_mux.sv
// ============================================================================
//  Module   : tb_usbh_reg_mux
//  Brief    : Directed vector bench for usbh_reg_mux (NCH=2, AW=9, TMO_W=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usbh_reg_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_cs, reg_wr;
    logic [8:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack, reg_err;
    logic [1:0]  ch_cs_o;
    logic        ch_wr_o;
    logic [5:0]  ch_addr_o;
    logic [31:0] ch_wdata_o;
    logic [3:0]  ch_be_o;
    logic [63:0] ch_rdata_i;
    logic [1:0]  ch_ack_i, ch_intr_i;
    logic        usb_intr_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    usbh_reg_mux #(.NCH(2), .AW(9), .TMO_W(4)) dut (
        .usb_clk_i  (clk),
        .usb_rstn_i (rst_n),
        .reg_cs     (reg_cs),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_be     (reg_be),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack),
        .reg_err    (reg_err),
        .ch_cs_o    (ch_cs_o),
        .ch_wr_o    (ch_wr_o),
        .ch_addr_o  (ch_addr_o),
        .ch_wdata_o (ch_wdata_o),
        .ch_be_o    (ch_be_o),
        .ch_rdata_i (ch_rdata_i),
        .ch_ack_i   (ch_ack_i),
        .ch_intr_i  (ch_intr_i),
        .usb_intr_o (usb_intr_o)
    );

    typedef struct {
        logic [8:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          dly;      // cs-active cycle in which the channel acks
        logic [31:0] cdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [1:0]  exp_cs;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One upstream access; channel responder acks on cs cycle 'dly' (0 = never),
    // and meanwhile acks from the non-selected channel to test they are ignored.
    task automatic access(input logic [8:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] be, input int dly, input logic [31:0] cd,
                          output logic [31:0] rd, output logic er, output logic [1:0] cs_seen,
                          output int lat, output int acks, output int cs_cyc);
        bit done;
        done = 0; lat = 0; acks = 0; cs_cyc = 0; cs_seen = '0; rd = '0; er = 1'b0;
        @(negedge clk);
        reg_cs = 1'b1; reg_wr = w; reg_addr = a; reg_wdata = wd; reg_be = be;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            ch_ack_i   = '0;
            ch_rdata_i = {32'hDEAD_0001, 32'hDEAD_0000};
            if (ch_cs_o != 2'b00) begin
                cs_cyc++;
                cs_seen |= ch_cs_o;
                if (cs_cyc == dly) begin
                    ch_ack_i = ch_cs_o;
                    if (ch_cs_o[1]) ch_rdata_i[63:32] = cd;
                    else            ch_rdata_i[31:0]  = cd;
                end else begin
                    ch_ack_i = ~ch_cs_o;
                end
            end
            if (reg_ack) begin
                acks++;
                rd = reg_rdata;
                er = reg_err;
                reg_cs = 1'b0;
                done = 1;
            end
        end
        reg_cs = 1'b0;
        chk("access_done", 32'(done), 32'd1);
        @(negedge clk);
        ch_ack_i = '0;
        if (reg_ack) acks++;
    endtask

    vec_t        vecs[12];
    logic [31:0] rd;
    logic        er;
    logic [1:0]  cs_seen;
    int          lat, acks, cs_cyc;

    initial begin
        rst_n = 1'b0; reg_cs = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
        reg_be = '0; ch_rdata_i = '0; ch_ack_i = '0; ch_intr_i = '0;

        vecs[0]  = '{9'h044, 1'b0, 32'h0,          4'hF, 3,  32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 2'b10, 4};
        vecs[1]  = '{9'h010, 1'b1, 32'h1234_5678,  4'hF, 1,  32'h0,         32'h0,         1'b0, 2'b01, 2};
        vecs[2]  = '{9'h000, 1'b0, 32'h0,          4'hF, 2,  32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2'b01, 3};
        vecs[3]  = '{9'h088, 1'b0, 32'h0,          4'hF, 0,  32'h0,         32'h0001_0002, 1'b0, 2'b00, 1};
        vecs[4]  = '{9'h0C0, 1'b0, 32'h0,          4'hF, 0,  32'h0,         32'hFFFF_FFFF, 1'b1, 2'b00, 1};
        vecs[5]  = '{9'h1FC, 1'b1, 32'h5555_5555,  4'hF, 0,  32'h0,         32'hFFFF_FFFF, 1'b1, 2'b00, 1};
        vecs[6]  = '{9'h090, 1'b0, 32'h0,          4'hF, 0,  32'h0,         32'h0,         1'b0, 2'b00, 1};
        vecs[7]  = '{9'h084, 1'b1, 32'h0000_0003,  4'h1, 0,  32'h0,         32'h0,         1'b0, 2'b00, 1};
        vecs[8]  = '{9'h084, 1'b0, 32'h0,          4'hF, 0,  32'h0,         32'h0000_0003, 1'b0, 2'b00, 1};
        vecs[9]  = '{9'h084, 1'b1, 32'h0,          4'hE, 0,  32'h0,         32'h0,         1'b0, 2'b00, 1};
        vecs[10] = '{9'h084, 1'b0, 32'h0,          4'hF, 0,  32'h0,         32'h0000_0003, 1'b0, 2'b00, 1};
        vecs[11] = '{9'h07C, 1'b0, 32'h0,          4'hF, 15, 32'h7E57_000F, 32'h7E57_000F, 1'b0, 2'b10, 16};

        repeat (3) @(negedge clk);
        chk("rst_ack",   32'(reg_ack),    32'd0);
        chk("rst_err",   32'(reg_err),    32'd0);
        chk("rst_rdata", reg_rdata,       32'd0);
        chk("rst_cs",    32'(ch_cs_o),    32'd0);
        chk("rst_intr",  32'(usb_intr_o), 32'd0);
        chk("rst_wr",    32'(ch_wr_o),    32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].be, vecs[i].dly,
                   vecs[i].cdata, rd, er, cs_seen, lat, acks, cs_cyc);
            if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i),  32'(er),      32'(vecs[i].exp_err));
            chk($sformatf("v%0d_cs", i),   32'(cs_seen), 32'(vecs[i].exp_cs));
            chk($sformatf("v%0d_lat", i),  32'(lat),     32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_acks", i), 32'(acks),    32'd1);
            if (vecs[i].exp_cs != 2'b00) begin
                chk($sformatf("v%0d_addr", i),  32'(ch_addr_o), 32'(vecs[i].addr[5:0]));
                chk($sformatf("v%0d_wr", i),    32'(ch_wr_o),   32'(vecs[i].wr));
                chk($sformatf("v%0d_wdata", i), ch_wdata_o,     vecs[i].wdata);
                chk($sformatf("v%0d_be", i),    32'(ch_be_o),   32'(vecs[i].be));
            end
        end

        // Interrupt: rising edge on ch0 with mask = 3
        @(negedge clk); ch_intr_i = 2'b01;
        @(negedge clk);
        chk("intr_lag", 32'(usb_intr_o), 32'd0);
        @(negedge clk);
        chk("intr_set", 32'(usb_intr_o), 32'd1);
        access(9'h080, 1'b0, 32'h0, 4'hF, 0, 32'h0, rd, er, cs_seen, lat, acks, cs_cyc);
        chk("sts_read", rd, 32'h1);
        access(9'h080, 1'b1, 32'h1, 4'h1, 0, 32'h0, rd, er, cs_seen, lat, acks, cs_cyc);
        chk("intr_clr", 32'(usb_intr_o), 32'd0);
        access(9'h080, 1'b0, 32'h0, 4'hF, 0, 32'h0, rd, er, cs_seen, lat, acks, cs_cyc);
        chk("sts_level_no_reset", rd, 32'h0);

        // Clear of bit 1 in the same cycle its rising edge arrives: set wins
        @(negedge clk);
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 9'h080; reg_wdata = 32'h2; reg_be = 4'h1;
        ch_intr_i = 2'b11;
        @(negedge clk);
        chk("setclr_ack", 32'(reg_ack), 32'd1);
        reg_cs = 1'b0;
        access(9'h080, 1'b0, 32'h0, 4'hF, 0, 32'h0, rd, er, cs_seen, lat, acks, cs_cyc);
        chk("setclr_sts", rd, 32'h2);
        chk("setclr_intr", 32'(usb_intr_o), 32'd1);
        access(9'h084, 1'b1, 32'h1, 4'h1, 0, 32'h0, rd, er, cs_seen, lat, acks, cs_cyc);
        chk("masked_intr", 32'(usb_intr_o), 32'd0);

`ifdef USBH_REG_MUX_TMO_EN
        access(9'h000, 1'b0, 32'h0, 4'hF, 0, 32'h0, rd, er, cs_seen, lat, acks, cs_cyc);
        chk("tmo_rdata",  rd,           32'hFFFF_FFFF);
        chk("tmo_err",    32'(er),      32'd1);
        chk("tmo_cs_cyc", 32'(cs_cyc),  32'd15);
        chk("tmo_lat",    32'(lat),     32'd16);
        chk("tmo_acks",   32'(acks),    32'd1);
`endif

        // Reset while a channel access is pending
        @(negedge clk);
        reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 9'h044; reg_be = 4'hF;
        repeat (3) @(negedge clk);
        chk("pre_rst_cs", 32'(ch_cs_o), 32'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cs",  32'(ch_cs_o), 32'd0);
        chk("rst_mid_ack", 32'(reg_ack), 32'd0);
        reg_cs = 1'b0;
        @(negedge clk);
        chk("rst_mid_noack", 32'(reg_ack), 32'd0);
        rst_n = 1'b1;
        access(9'h084, 1'b0, 32'h0, 4'hF, 0, 32'h0, rd, er, cs_seen, lat, acks, cs_cyc);
        chk("rst_mask", rd, 32'h0);
        access(9'h044, 1'b0, 32'h0, 4'hF, 2, 32'h1357_9BDF, rd, er, cs_seen, lat, acks, cs_cyc);
        chk("post_rst_rdata", rd,           32'h1357_9BDF);
        chk("post_rst_err",   32'(er),      32'd0);
        chk("post_rst_cs",    32'(cs_seen), 32'b10);
        chk("post_rst_lat",   32'(lat),     32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
